// File: rtl/mem_stage_hs_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The stage holds mem_addr / mem_write_data / mem_write_en stable while mem_req is high.
interface mem_stage_hs_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_write_data,
    output mem_write_en,
    input  mem_ack,
    input  mem_read_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_write_data,
    input  mem_write_en,
    output mem_ack,
    output mem_read_data
  );
endinterface

// File: rtl/mem_stage_hs.sv
// mips_16 MEM stage with a variable-latency req/ack data-memory port, pipeline stall,
// timeout watchdog and IRST-selected random-number reads.
module mem_stage_hs #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W+6:0]   pipeline_reg_in,
  output logic [2*DATA_W+4:0]   pipeline_reg_out,
  output logic [2:0]            mem_op_dest,
  input  logic [DATA_W-1:0]     irst_reg_data,
  input  logic [DATA_W-1:0]     rand_data_in,
  mem_stage_hs_if.master        dmem,
  output logic                  mem_stall,
  output logic                  mem_timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Last legal WAIT count before the watchdog aborts the access.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  // Field decode of the EX/MEM pipeline register.
  logic [DATA_W-1:0] alu_result;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [4:0]        wb_field;
  logic              op;
  logic              rnd;

  assign alu_result = pipeline_reg_in[2*DATA_W+6:DATA_W+7];
  assign rd_en      = pipeline_reg_in[DATA_W+6];
  assign wr_en      = pipeline_reg_in[DATA_W+5];
  assign wr_data    = pipeline_reg_in[DATA_W+4:5];
  assign wb_field   = pipeline_reg_in[4:0];

  assign op  = rd_en | wr_en;
  assign rnd = rd_en & ~wr_en & irst_reg_data[DATA_W-1];

  // Only the select bit of IRST matters to this stage.
  logic unused_irst_bits;
  assign unused_irst_bits = ^irst_reg_data[DATA_W-2:0];

  assign mem_op_dest = pipeline_reg_in[3:1];

  state_e              state_q, state_d;
  logic [2*DATA_W+4:0] out_q, out_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                expired;
  logic                stall;

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    out_d     = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op && !rnd) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          addr_d  = alu_result;
          wdata_d = wr_data;
          wen_d   = wr_en;
          cnt_d   = '0;
        end else begin
          out_d = {alu_result, (rnd ? rand_data_in : {DATA_W{1'b0}}), wb_field};
        end
      end

      ST_WAIT: begin
        stall = ~dmem.mem_ack & ~expired;
        // An ack on the expiry cycle still completes the access normally.
        if (dmem.mem_ack) begin
          state_d = ST_IDLE;
          out_d   = {alu_result, (wen_q ? {DATA_W{1'b0}} : dmem.mem_read_data), wb_field};
        end else if (expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          out_d     = {alu_result, {DATA_W{1'b0}}, 1'b0, wb_field[3:0]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pipeline_reg_out     = out_q;
  assign dmem.mem_req         = (state_q == ST_WAIT);
  assign dmem.mem_addr        = addr_q;
  assign dmem.mem_write_data  = wdata_q;
  assign dmem.mem_write_en    = wen_q;
  assign mem_stall            = stall;
  assign mem_timeout          = timeout_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Random instruction stream against mem_stage_hs with a latency-programmable memory
// responder; a scoreboard queue holds the expected result of every instruction.
module tb_mem_stage_hs;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [38:0] pin;
  logic [36:0] pout;
  logic [2:0]  dest;
  logic [15:0] irst;
  logic [15:0] rnd_d;
  logic        stall;
  logic        tmo;

  mem_stage_hs_if #(.DATA_W(DW)) dmem ();

  mem_stage_hs #(.DATA_W(DW), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_reg_in  (pin),
    .pipeline_reg_out (pout),
    .mem_op_dest      (dest),
    .irst_reg_data    (irst),
    .rand_data_in     (rnd_d),
    .dmem             (dmem),
    .mem_stall        (stall),
    .mem_timeout      (tmo)
  );

  typedef struct {
    logic [36:0] out;
    int          bub;
    int          req;
    logic        tmo;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;

  logic [15:0] resp_mem[16];
  logic [15:0] ref_mem[16];
  logic        tmo_model = 1'b0;

  // Shared between driver, responder and monitor.
  bit          resp_en  = 1'b0;
  bit          in_valid = 1'b0;
  int          lat_cur  = 0;
  logic [15:0] exp_addr;
  logic [15:0] exp_wdata;
  logic        exp_wen;
  logic [2:0]  cur_dest;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory responder: acks in the lat_cur-th request cycle; lat_cur==0 never acks.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (dmem.mem_req) begin
        wcnt++;
        chk("mem_addr", dmem.mem_addr, exp_addr);
        chk("mem_write_data", dmem.mem_write_data, exp_wdata);
        chk("mem_write_en", dmem.mem_write_en, exp_wen);
        if (wcnt == lat_cur) begin
          dmem.mem_ack = 1'b1;
          if (dmem.mem_write_en) begin
            dmem.mem_read_data = 16'($urandom);
            resp_mem[dmem.mem_addr[3:0]] = dmem.mem_write_data;
          end else begin
            dmem.mem_read_data = resp_mem[dmem.mem_addr[3:0]];
          end
        end else begin
          dmem.mem_ack       = 1'b0;
          dmem.mem_read_data = 16'($urandom);
        end
      end else begin
        dmem.mem_ack = 1'b0;
        wcnt         = 0;
      end
    end
  end

  // Monitor: the cycle after an instruction is accepted (stall low) its result is on pout.
  bit   prev_acc = 1'b0;
  bit   prev_bub = 1'b0;
  int   bub_cnt  = 0;
  int   req_cnt  = 0;
  int   txn      = 0;
  exp_t e;
  always @(negedge clk) begin
    if (prev_acc) begin
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty actual=result required=no_result");
      end else begin
        e = sbq.pop_front();
        chk("out", pout, e.out);
        chk("bubbles", bub_cnt, e.bub);
        chk("req_cycles", req_cnt, e.req);
        chk("mem_timeout", tmo, e.tmo);
        $display("txn %0d out=%h bubbles=%0d req_cycles=%0d timeout=%0b", txn, pout, bub_cnt, req_cnt, tmo);
        txn++;
      end
      bub_cnt = 0;
      req_cnt = 0;
    end else if (prev_bub) begin
      chk("bubble_out", pout, 37'h0);
      bub_cnt++;
    end
    if (in_valid) begin
      chk("mem_op_dest", dest, cur_dest);
      req_cnt += int'(dmem.mem_req);
    end
    prev_acc = in_valid && !stall;
    prev_bub = in_valid && stall;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          kind, r, lat, n;
    logic [15:0] alu, wd, ir, rv, rdv;
    logic [4:0]  wb;
    logic        rd, wr, rndop;
    exp_t        x;

    rst = 1'b1;
    pin = '0;
    irst = '0;
    rnd_d = '0;
    dmem.mem_ack = 1'b0;
    dmem.mem_read_data = '0;
    for (int i = 0; i < 16; i++) begin
      rdv = 16'($urandom);
      resp_mem[i] = rdv;
      ref_mem[i]  = rdv;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", pout, 37'h0);
    chk("rst_mem_req", dmem.mem_req, 1'b0);
    chk("rst_mem_addr", dmem.mem_addr, 16'h0);
    chk("rst_mem_write_data", dmem.mem_write_data, 16'h0);
    chk("rst_mem_write_en", dmem.mem_write_en, 1'b0);
    chk("rst_mem_timeout", tmo, 1'b0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_en = 1'b1;

    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      kind = $urandom_range(0, 4);
      if (i == 3) kind = 2;
      alu = 16'($urandom);
      wd  = 16'($urandom);
      wb  = 5'($urandom);
      ir  = 16'($urandom);
      rv  = 16'($urandom);
      rd  = (kind == 1) || (kind == 3);
      wr  = (kind == 2) || (kind == 4);
      if (kind != 0) ir[15] = (kind >= 3);
      r   = $urandom_range(0, 9);
      lat = (r < 2) ? 0 : ((r == 2) ? 15 : $urandom_range(1, 4));
      if (i == 3) lat = 0;

      // Reference behaviour of one instruction.
      rndop = rd && !wr && ir[15];
      if (!(rd || wr) || rndop) begin
        x.out = {alu, (rndop ? rv : 16'h0), wb};
        x.bub = 0;
        x.req = 0;
      end else if (lat == 0) begin
        tmo_model = 1'b1;
        x.out = {alu, 16'h0, 1'b0, wb[3:0]};
        x.bub = TMO;
        x.req = TMO;
      end else begin
        x.out = {alu, (wr ? 16'h0 : ref_mem[alu[3:0]]), wb};
        if (wr) ref_mem[alu[3:0]] = wd;
        x.bub = lat;
        x.req = lat;
      end
      x.tmo = tmo_model;
      sbq.push_back(x);

      pin       = {alu, rd, wr, wd, wb};
      irst      = ir;
      rnd_d     = rv;
      lat_cur   = lat;
      exp_addr  = alu;
      exp_wdata = wd;
      exp_wen   = wr;
      cur_dest  = wb[3:1];
      in_valid  = 1'b1;

      @(negedge clk);
      n = 0;
      while (stall && n < 40) begin
        @(posedge clk);
        #1;
        irst  = 16'($urandom);
        rnd_d = 16'($urandom);
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        failures++;
        $display("FAIL stall_bound actual=%0d required=<40", n);
      end
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pin  = '0;
    irst = '0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    chk("mem_timeout_sticky", tmo, tmo_model);

    // Reset in the 2nd WAIT cycle of a read, then a late ack while idle.
    @(posedge clk);
    #1;
    pin       = {16'h0040, 1'b1, 1'b0, 16'h0000, 5'b10110};
    lat_cur   = 3;
    exp_addr  = 16'h0040;
    exp_wdata = 16'h0000;
    exp_wen   = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    resp_en = 1'b0;
    dmem.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pin = {16'h1111, 1'b0, 1'b0, 16'h2222, 5'b10110};
    dmem.mem_ack = 1'b1;
    dmem.mem_read_data = 16'hDEAD;
    @(negedge clk);
    chk("rst_wait_out", pout, 37'h0);
    chk("rst_wait_mem_req", dmem.mem_req, 1'b0);
    chk("rst_wait_timeout", tmo, 1'b0);
    chk("rst_wait_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    dmem.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_out", pout, {16'h1111, 16'h0000, 5'b10110});
    chk("idle_ack_mem_req", dmem.mem_req, 1'b0);
    chk("idle_ack_timeout", tmo, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
